aclint_timer: RTL and testbench
===============================

ACLINT_TIMER -- requirements
Module: aclint_timer

Interface
REQ-001 Parameter PRESCALE, default 1: number of clk cycles per mtime increment, legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a  input  16  byte offset within the timer window 0x9b000000; bits [1:0] are ignored.
REQ-005 d  input  32  write data.
REQ-006 we  input  1  write strobe, one-cycle pulse, qualified by a.
REQ-007 spo  output  32  registered read data for the current a.
REQ-008 irq_timer  output  1  machine timer interrupt, level.
REQ-009 irq_soft  output  1  machine software interrupt, level.

Function
REQ-010 Register map, word offsets (a & 0xfffc), each 32 bits, read/write:
- 0x0000 msip: bit0 only; bits [31:1] read 0.
- 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
- 0xbff8 mtime[31:0]; 0xbffc mtime[63:32].
REQ-011 Any other offset shall read 0, and writes to it shall be ignored.
REQ-012 Prescaler: a 16-bit counter counts 0..PRESCALE-1 and wraps to 0; a tick occurs on the cycle it holds PRESCALE-1; with PRESCALE=1 a tick occurs every cycle.
REQ-013 On a tick, mtime increments by 1 modulo 2^64, with a full 64-bit carry from the low to the high word in the same cycle.
REQ-014 mtime wrap-around: 0xFFFFFFFF_FFFFFFFF + 1 -> 0; no flag is raised.
REQ-015 Write to mtime low or high on a tick cycle: the written half takes d, the other half keeps its old value, and no increment is applied that cycle.
REQ-016 A write to mtime does not reset the prescaler.
REQ-017 Writes to mtimecmp halves and to msip take effect on the next edge.
REQ-018 spo is registered: spo at edge N+1 equals the register selected by a at edge N.
REQ-019 spo read latency is 1 cycle; callers hold a stable for at least 2 cycles.
REQ-020 Read-during-write to the same register: spo shows the pre-write value in the cycle after the write and the new value one cycle later.
REQ-021 irq_timer is registered: irq_timer <= (mtime >= mtimecmp), unsigned 64-bit compare using the post-update values of both registers. It asserts 1 cycle after the condition becomes true.
REQ-022 irq_timer deasserts 1 cycle after a mtimecmp or mtime write makes the condition false; it is not sticky and needs no acknowledge.
REQ-023 Split 32-bit updates of mtimecmp are not atomic; a transient irq_timer between the two writes is permitted (software writes the high word 0xFFFFFFFF first).
REQ-024 irq_soft is registered and equals msip bit0, 1 cycle after the write.
REQ-025 No read side effects; no rd strobe exists.

Reset
REQ-026 While rst=1 on an edge: mtime=0, prescaler=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, msip=0, spo=0, irq_timer=0, irq_soft=0.
REQ-027 Reset has priority over we and over a tick in the same cycle.
REQ-028 Asserting rst mid-count discards the partial prescale count.
REQ-029 After reset deassert, with PRESCALE=1 the first increment is seen on the first edge with rst=0.

Verification
REQ-030 PRESCALE=1, reset then 10 idle cycles, a=0xbff8 -> spo=10 ±1 per the read latency; mtime high word reads 0; irq_timer=0.
REQ-031 PRESCALE=4: count 12 cycles after reset -> mtime=3; write mtime low=5 on a tick cycle -> next read 5, not 6.
REQ-032 Carry and wrap:
- Write mtime high=0, low=0xFFFFFFFF (PRESCALE=1) -> after 1 tick, high=1 and low=0.
- Write high=low=0xFFFFFFFF -> after 1 tick, both halves read 0.
REQ-033 Timer interrupt:
- Write mtimecmp high=0, low=20 with mtime<20 -> irq_timer rises exactly 1 cycle after mtime reaches 20.
- Write mtimecmp high=0xFFFFFFFF -> irq_timer falls 1 cycle later.
REQ-034 Software interrupt and unmapped offsets:
- Write msip=0xFFFFFFFF -> msip reads 1, irq_soft=1.
- Write msip=0 -> irq_soft=0.
- Write to 0x1234 -> all registers unchanged, read returns 0.
REQ-035 Assert rst for 1 cycle with irq_timer=1 and mtime=0x1_00000000 -> all outputs and registers match REQ-026 on the next cycle.

Source files
------------

// File: rtl/aclint_timer.sv
// ACLINT-style machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// msip software-interrupt bit, registered read port and level interrupts.
module aclint_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq_timer,
  output logic        irq_soft
);

  localparam logic [15:0] PS_MAX       = 16'(PRESCALE - 1);
  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO = 16'hbff8;
  localparam logic [15:0] OFF_MTIME_HI = 16'hbffc;

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] spo_q, spo_d;
  logic        irq_timer_q, irq_timer_d;
  logic        irq_soft_q, irq_soft_d;

  logic [15:0] word_a;
  logic        tick;
  logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;

  // Address decode on the word offset; the byte-lane bits are don't-care.
  always_comb begin
    word_a      = a & 16'hfffc;
    wr_msip     = we && (word_a == OFF_MSIP);
    wr_cmp_lo   = we && (word_a == OFF_CMP_LO);
    wr_cmp_hi   = we && (word_a == OFF_CMP_HI);
    wr_mtime_lo = we && (word_a == OFF_MTIME_LO);
    wr_mtime_hi = we && (word_a == OFF_MTIME_HI);
  end

  // Prescaler: free-running 0..PRESCALE-1; mtime writes do not disturb it.
  always_comb begin
    tick    = (presc_q == PS_MAX);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // mtime next value: a software write to either half wins over the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = d;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = d;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtimecmp and msip next values from register writes.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_cmp_lo) mtimecmp_d[31:0]  = d;
    if (wr_cmp_hi) mtimecmp_d[63:32] = d;
    if (wr_msip)   msip_d            = d[0];
  end

  // Read mux and interrupt levels, all sampled from current register state.
  always_comb begin
    spo_d = 32'd0;
    unique case (word_a)
      OFF_MSIP:     spo_d = {31'd0, msip_q};
      OFF_CMP_LO:   spo_d = mtimecmp_q[31:0];
      OFF_CMP_HI:   spo_d = mtimecmp_q[63:32];
      OFF_MTIME_LO: spo_d = mtime_q[31:0];
      OFF_MTIME_HI: spo_d = mtime_q[63:32];
      default:      spo_d = 32'd0;
    endcase
    irq_timer_d = (mtime_q >= mtimecmp_q);
    irq_soft_d  = msip_q;
  end

  // State registers; synchronous reset overrides writes and ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= 16'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hffff_ffff_ffff_ffff;
      msip_q      <= 1'b0;
      spo_q       <= 32'd0;
      irq_timer_q <= 1'b0;
      irq_soft_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      spo_q       <= spo_d;
      irq_timer_q <= irq_timer_d;
      irq_soft_q  <= irq_soft_d;
    end
  end

  assign spo       = spo_q;
  assign irq_timer = irq_timer_q;
  assign irq_soft  = irq_soft_q;

endmodule

// File: tb/tb_aclint_timer.sv
// Bench for aclint_timer: two instances (PRESCALE=1 and PRESCALE=4) share one
// stimulus stream; a behavioural model of each is checked every cycle, with
// directed scenarios first and a randomized phase afterwards.
module tb_aclint_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo1, spo4;
  logic        irq_timer1, irq_timer4, irq_soft1, irq_soft4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aclint_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we),
    .spo(spo1), .irq_timer(irq_timer1), .irq_soft(irq_soft1)
  );

  aclint_timer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we),
    .spo(spo4), .irq_timer(irq_timer4), .irq_soft(irq_soft4)
  );

  // Behavioural model, index 0 -> PRESCALE=1, index 1 -> PRESCALE=4.
  int unsigned ps      [2];
  int unsigned m_pc    [2];
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  logic [31:0] m_spo   [2];
  logic        m_irqt  [2];
  logic        m_irqs  [2];

  function automatic logic [31:0] m_read(int k, logic [15:0] addr);
    int unsigned w;
    w = int'(addr) / 4 * 4;
    if (w == 32'h0000) return {31'd0, m_msip[k]};
    if (w == 32'h4000) return m_cmp[k][31:0];
    if (w == 32'h4004) return m_cmp[k][63:32];
    if (w == 32'hbff8) return m_mtime[k][31:0];
    if (w == 32'hbffc) return m_mtime[k][63:32];
    return 32'd0;
  endfunction

  function automatic void m_step();
    int unsigned w;
    bit          tick;
    w = int'(a) / 4 * 4;
    for (int k = 0; k < 2; k++) begin
      m_spo[k]  = m_read(k, a);
      m_irqt[k] = (m_mtime[k] >= m_cmp[k]);
      m_irqs[k] = m_msip[k];
      if (rst) begin
        m_pc[k] = 0; m_mtime[k] = 64'd0; m_cmp[k] = '1; m_msip[k] = 1'b0;
        m_spo[k] = 32'd0; m_irqt[k] = 1'b0; m_irqs[k] = 1'b0;
      end else begin
        tick    = (m_pc[k] == ps[k] - 1);
        m_pc[k] = tick ? 0 : m_pc[k] + 1;
        if (we && w == 32'hbff8)      m_mtime[k] = {m_mtime[k][63:32], d};
        else if (we && w == 32'hbffc) m_mtime[k] = {d, m_mtime[k][31:0]};
        else if (tick)                m_mtime[k] = m_mtime[k] + 1;
        if (we && w == 32'h4000) m_cmp[k] = {m_cmp[k][63:32], d};
        if (we && w == 32'h4004) m_cmp[k] = {d, m_cmp[k][31:0]};
        if (we && w == 32'h0000) m_msip[k] = d[0];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    chk("spo_p1",  spo1, m_spo[0]);
    chk("irqt_p1", {31'd0, irq_timer1}, {31'd0, m_irqt[0]});
    chk("irqs_p1", {31'd0, irq_soft1},  {31'd0, m_irqs[0]});
    chk("spo_p4",  spo4, m_spo[1]);
    chk("irqt_p4", {31'd0, irq_timer4}, {31'd0, m_irqt[1]});
    chk("irqs_p4", {31'd0, irq_soft4},  {31'd0, m_irqs[1]});
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  initial begin
    logic [15:0] offs [5];
    int          sel;
    ps[0] = 1; ps[1] = 4;
    offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
    offs[3] = 16'hbff8; offs[4] = 16'hbffc;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_mtime[k] = 0; m_cmp[k] = '1; m_msip[k] = 0;
      m_spo[k] = 0; m_irqt[k] = 0; m_irqs[k] = 0;
    end
    rst = 1'b1; a = 16'h0000; d = 32'd0; we = 1'b0;
    #1;

    // Reset state
    cycle(); cycle();
    chk("rst_spo", spo1, 32'd0);
    chk("rst_irqt", {31'd0, irq_timer1}, 32'd0);

    // Free-running count with both prescalers
    rst = 1'b0; a = 16'hbff8;
    repeat (10) cycle();
    chk("mtime_after10", {31'd0, (spo1 >= 32'd9 && spo1 <= 32'd11)}, 32'd1);
    chk("irqt_idle", {31'd0, irq_timer1}, 32'd0);
    repeat (3) cycle();
    chk("p4_mtime12", spo4, 32'd3);
    a = 16'hbffc; cycle(); cycle();
    chk("mtime_hi_zero", spo1, 32'd0);

    // Write mtime low on a PRESCALE=4 tick cycle: no increment that cycle
    a = 16'hbff8;
    for (int i = 0; i < 8 && m_pc[1] != 3; i++) cycle();
    wr(16'hbff8, 32'd5);
    cycle();
    chk("p4_write_on_tick", spo4, 32'd5);

    // Low-to-high carry, then full 64-bit wrap
    wr(16'hbffc, 32'd0); wr(16'hbff8, 32'hffff_ffff);
    a = 16'hbffc; cycle(); cycle();
    chk("carry_hi", spo1, 32'd1);
    wr(16'hbffc, 32'hffff_ffff); wr(16'hbff8, 32'hffff_ffff);
    a = 16'hbffc; cycle(); cycle();
    chk("wrap_hi", spo1, 32'd0);

    // Timer interrupt rise one cycle after mtime reaches mtimecmp, and fall
    rst = 1'b1; cycle(); rst = 1'b0;
    wr(16'h4004, 32'd0); wr(16'h4000, 32'd20);
    a = 16'h0000;
    repeat (18) cycle();
    chk("irqt_before", {31'd0, irq_timer1}, 32'd0);
    cycle();
    chk("irqt_rise", {31'd0, irq_timer1}, 32'd1);
    wr(16'h4004, 32'hffff_ffff);
    chk("irqt_hold", {31'd0, irq_timer1}, 32'd1);
    cycle();
    chk("irqt_fall", {31'd0, irq_timer1}, 32'd0);

    // Software interrupt and unmapped offset
    wr(16'h0000, 32'hffff_ffff);
    a = 16'h0000; cycle();
    chk("msip_read", spo1, 32'd1);
    chk("irqs_set", {31'd0, irq_soft1}, 32'd1);
    wr(16'h0000, 32'd0); cycle();
    chk("irqs_clr", {31'd0, irq_soft1}, 32'd0);
    wr(16'h1234, $urandom);
    a = 16'h1234; cycle();
    chk("unmapped_read", spo1, 32'd0);
    a = 16'h4004; cycle();
    chk("cmp_hi_kept", spo1, 32'hffff_ffff);

    // Reset with interrupt active and mtime = 0x1_00000000
    wr(16'h4004, 32'd0); wr(16'h4000, 32'd0);
    wr(16'hbffc, 32'd1); wr(16'hbff8, 32'd0);
    chk("pre_rst_irqt", {31'd0, irq_timer1}, 32'd1);
    rst = 1'b1; cycle();
    chk("post_rst_spo", spo1, 32'd0);
    chk("post_rst_irqt", {31'd0, irq_timer1}, 32'd0);
    chk("post_rst_irqs", {31'd0, irq_soft1}, 32'd0);
    rst = 1'b0; a = 16'h4000; cycle();
    chk("post_rst_cmp", spo1, 32'hffff_ffff);
    a = 16'hbff8; cycle();
    chk("post_rst_mtime", spo1, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 5));
      a   = (sel < 5) ? (offs[sel] | 16'($urandom_range(0, 3))) : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'hffff_ffff;
        default: d = $urandom_range(0, 64);
      endcase
      we  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    we = 1'b0; rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
